// File: rtl/router_pkg.sv
// Shared router definitions: flit type field, input-VC state encodings and
// basic sizes used across the VC router.
package router_pkg;

  localparam int unsigned FLIT_SIZE = 34;  // 2-bit type + 32-bit payload
  localparam int unsigned VC_SIZE   = 4;   // VCs per router port

  // Flit type lives in the top two bits of every flit.
  typedef enum logic [1:0] {
    BODY      = 2'b00,
    HEAD      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_t;

  // Input VC life cycle: route compute, wait for an output VC, send, stall on credits.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ROUTING = 3'd1,
    WAITING = 3'd2,
    ACTIVE  = 3'd3,
    CREDITS = 3'd4
  } vc_state_t;

  function automatic flit_type_t get_flit_type(input logic [FLIT_SIZE-1:0] flit);
    return flit_type_t'(flit[FLIT_SIZE-1 -: 2]);
  endfunction

endpackage

// File: rtl/out_port_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// Ports: req  - request vector
//        ptr  - highest-priority index this cycle (owned by the caller)
//        gnt  - one-hot grant (zero when no request)
//        winner - index of the granted requester
//        any  - at least one request present
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  int unsigned w_idx;

  // Scan from ptr upward with wrap; first requester found wins.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    gnt    = '0;
    w_idx  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      w_idx = 32'(ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!any && req[IDX_W'(w_idx)]) begin
        any    = 1'b1;
        winner = IDX_W'(w_idx);
      end
    end
    if (any) gnt[winner] = 1'b1;
  end

endmodule

// File: rtl/out_port_sched.sv
// out_port_sched: per-output-port scheduler of the VC router. Allocates
// output VCs to waiting head flits, arbitrates one crossbar flit per cycle
// and tracks downstream credits per output VC.
// Ports: clk/rst (sync, active-high)
//        req/req_head/req_tail - per input VC head-of-queue status
//        gnt/gnt_ovc           - crossbar grant and output VC tag
//        credit_valid/credit_vc- credit return from downstream
//        ovc_busy/credit_cnt   - output VC ownership and credit counters
//        credit_err            - sticky credit overflow flag
module out_port_sched
  import router_pkg::*;
#(
  parameter  int unsigned NUM_IN     = 20,
  parameter  int unsigned NUM_OVC    = 4,
  parameter  int unsigned CREDIT_MAX = 4,
  parameter  int unsigned OVC_W      = 2,
  localparam int unsigned CNT_W      = $clog2(CREDIT_MAX + 1),
  localparam int unsigned IN_W       = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        req,
  input  logic [NUM_IN-1:0]        req_head,
  input  logic [NUM_IN-1:0]        req_tail,
  output logic [NUM_IN-1:0]        gnt,
  output logic [OVC_W-1:0]         gnt_ovc,
  input  logic                     credit_valid,
  input  logic [OVC_W-1:0]         credit_vc,
  output logic [NUM_OVC-1:0]       ovc_busy,
  output logic [NUM_OVC*CNT_W-1:0] credit_cnt,
  output logic                     credit_err
);

  logic [NUM_IN-1:0]  r_has_ovc;
  logic [OVC_W-1:0]   r_ovc_of [NUM_IN];
  logic [NUM_OVC-1:0] r_busy;
  logic [CNT_W-1:0]   r_cnt [NUM_OVC];
  logic [IN_W-1:0]    r_va_ptr;
  logic [IN_W-1:0]    r_sa_ptr;
  logic               r_credit_err;

  logic [NUM_IN-1:0]  w_va_req, w_va_gnt, w_sa_req, w_sa_gnt;
  logic [IN_W-1:0]    w_va_win, w_sa_win;
  logic               w_va_any, w_sa_any;
  logic               w_free_any, w_alloc, w_release;
  logic [OVC_W-1:0]   w_free_vc, w_sa_ovc;
  logic [NUM_OVC-1:0] w_busy_set, w_busy_clr, w_inc, w_dec;

  // VC allocation: heads without an output VC compete for the lowest free VC.
  assign w_va_req = req & req_head & ~r_has_ovc;

  always_comb begin
    w_free_any = 1'b0;
    w_free_vc  = '0;
    for (int v = NUM_OVC - 1; v >= 0; v--) begin
      if (!r_busy[v]) begin
        w_free_any = 1'b1;
        w_free_vc  = OVC_W'(v);
      end
    end
  end

  rr_arbiter #(.N(NUM_IN)) u_va_arb (
    .req    (w_va_req),
    .ptr    (r_va_ptr),
    .gnt    (w_va_gnt),
    .winner (w_va_win),
    .any    (w_va_any)
  );

  assign w_alloc = w_va_any & w_free_any;

  // Switch allocation: VC owners with at least one downstream credit.
  always_comb begin
    w_sa_req = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      w_sa_req[i] = req[i] & r_has_ovc[i] & (r_cnt[r_ovc_of[i]] != '0);
    end
  end

  rr_arbiter #(.N(NUM_IN)) u_sa_arb (
    .req    (w_sa_req),
    .ptr    (r_sa_ptr),
    .gnt    (w_sa_gnt),
    .winner (w_sa_win),
    .any    (w_sa_any)
  );

  assign w_sa_ovc  = r_ovc_of[w_sa_win];
  assign w_release = w_sa_any & req_tail[w_sa_win];

  // Grant is combinational and forced quiet while reset is held.
  assign gnt     = rst ? '0 : w_sa_gnt;
  assign gnt_ovc = (rst || !w_sa_any) ? '0 : w_sa_ovc;

  // Per-VC set/clear and credit up/down strobes.
  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    w_inc      = '0;
    w_dec      = '0;
    if (w_alloc)   w_busy_set[w_free_vc] = 1'b1;
    if (w_release) w_busy_clr[w_sa_ovc]  = 1'b1;
    for (int unsigned v = 0; v < NUM_OVC; v++) begin
      w_inc[v] = credit_valid && (credit_vc == OVC_W'(v));
      w_dec[v] = w_sa_any && (w_sa_ovc == OVC_W'(v));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_has_ovc    <= '0;
      r_busy       <= '0;
      r_va_ptr     <= '0;
      r_sa_ptr     <= '0;
      r_credit_err <= 1'b0;
      for (int unsigned i = 0; i < NUM_IN; i++) r_ovc_of[i] <= '0;
      for (int unsigned v = 0; v < NUM_OVC; v++) r_cnt[v] <= CNT_W'(CREDIT_MAX);
    end else begin
      if (w_alloc) begin
        r_ovc_of[w_va_win] <= w_free_vc;
        r_va_ptr <= (w_va_win == IN_W'(NUM_IN - 1)) ? '0 : w_va_win + IN_W'(1);
      end
      if (w_sa_any) begin
        r_sa_ptr <= (w_sa_win == IN_W'(NUM_IN - 1)) ? '0 : w_sa_win + IN_W'(1);
      end
      // VA and SA winners are disjoint (has_ovc differs), so set/clear never collide.
      r_has_ovc <= (r_has_ovc | (w_alloc ? w_va_gnt : '0)) & ~(w_release ? w_sa_gnt : '0);
      r_busy    <= (r_busy | w_busy_set) & ~w_busy_clr;
      // Simultaneous grant and return cancel; overflow saturates and latches the error.
      for (int unsigned v = 0; v < NUM_OVC; v++) begin
        if (w_inc[v] && !w_dec[v]) begin
          if (r_cnt[v] == CNT_W'(CREDIT_MAX)) r_credit_err <= 1'b1;
          else                                r_cnt[v]     <= r_cnt[v] + CNT_W'(1);
        end else if (w_dec[v] && !w_inc[v]) begin
          r_cnt[v] <= r_cnt[v] - CNT_W'(1);
        end
      end
    end
  end

  assign ovc_busy   = r_busy;
  assign credit_err = r_credit_err;

  for (genvar v = 0; v < NUM_OVC; v++) begin : g_cnt
    assign credit_cnt[v*CNT_W +: CNT_W] = r_cnt[v];
  end

endmodule

// File: tb/tb_out_port_sched.sv
// Bench for out_port_sched: packet sources per input VC, a reference model
// of the allocation/credit rules checked every cycle, plus directed literals.
module tb_out_port_sched;

  localparam int unsigned NUM_IN     = 20;
  localparam int unsigned NUM_OVC    = 4;
  localparam int unsigned CREDIT_MAX = 4;
  localparam int unsigned OVC_W      = 2;
  localparam int unsigned CNT_W      = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_IN-1:0]        req, req_head, req_tail, gnt;
  logic [OVC_W-1:0]         gnt_ovc;
  logic                     credit_valid;
  logic [OVC_W-1:0]         credit_vc;
  logic [NUM_OVC-1:0]       ovc_busy;
  logic [NUM_OVC*CNT_W-1:0] credit_cnt;
  logic                     credit_err;

  always #5 clk = ~clk;

  out_port_sched #(
    .NUM_IN(NUM_IN), .NUM_OVC(NUM_OVC), .CREDIT_MAX(CREDIT_MAX), .OVC_W(OVC_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_head(req_head), .req_tail(req_tail),
    .gnt(gnt), .gnt_ovc(gnt_ovc), .credit_valid(credit_valid), .credit_vc(credit_vc),
    .ovc_busy(ovc_busy), .credit_cnt(credit_cnt), .credit_err(credit_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet sources: input i holds a packet of src_len flits, src_pos already sent.
  int src_len [NUM_IN];
  int src_pos [NUM_IN];

  task automatic drive_inputs();
    for (int i = 0; i < NUM_IN; i++) begin
      req[i]      = src_pos[i] < src_len[i];
      req_head[i] = req[i] && (src_pos[i] == 0);
      req_tail[i] = req[i] && (src_pos[i] == src_len[i] - 1);
    end
  endtask

  task automatic new_pkt(input int i, input int len);
    src_len[i] = len;
    src_pos[i] = 0;
  endtask

  // Reference model state (value after the most recent clock edge).
  bit m_valid = 1'b0;
  bit m_has  [NUM_IN];
  int m_ovc  [NUM_IN];
  bit m_busy [NUM_OVC];
  int m_cnt  [NUM_OVC];
  int m_va_ptr, m_sa_ptr;
  bit m_err;

  always @(negedge clk) begin
    int sa_w, va_w, free_v, inc, dec;
    logic [NUM_IN-1:0]        exp_gnt;
    logic [NUM_OVC-1:0]       exp_busy;
    logic [NUM_OVC*CNT_W-1:0] exp_cnt;

    if (m_valid) begin
      for (int v = 0; v < NUM_OVC; v++) begin
        exp_busy[v] = m_busy[v];
        exp_cnt[v*CNT_W +: CNT_W] = CNT_W'(m_cnt[v]);
      end
      chk("model_ovc_busy", ovc_busy, exp_busy);
      chk("model_credit_cnt", credit_cnt, exp_cnt);
      chk("model_credit_err", credit_err, m_err);
    end

    sa_w = -1;
    va_w = -1;
    free_v = -1;
    if (!rst && m_valid) begin
      for (int k = 0; k < NUM_IN; k++) begin
        int i;
        i = (m_sa_ptr + k) % NUM_IN;
        if (sa_w < 0 && req[i] && m_has[i] && m_cnt[m_ovc[i]] > 0) sa_w = i;
      end
      for (int k = 0; k < NUM_IN; k++) begin
        int i;
        i = (m_va_ptr + k) % NUM_IN;
        if (va_w < 0 && req[i] && req_head[i] && !m_has[i]) va_w = i;
      end
      for (int v = NUM_OVC - 1; v >= 0; v--) if (!m_busy[v]) free_v = v;
    end

    exp_gnt = '0;
    if (sa_w >= 0) exp_gnt[sa_w] = 1'b1;
    chk("model_gnt", gnt, exp_gnt);
    if (sa_w >= 0) chk("model_gnt_ovc", gnt_ovc, m_ovc[sa_w]);

    if (rst) begin
      for (int i = 0; i < NUM_IN; i++) begin m_has[i] = 0; m_ovc[i] = 0; end
      for (int v = 0; v < NUM_OVC; v++) begin m_busy[v] = 0; m_cnt[v] = CREDIT_MAX; end
      m_va_ptr = 0;
      m_sa_ptr = 0;
      m_err    = 0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      for (int v = 0; v < NUM_OVC; v++) begin
        inc = (credit_valid && credit_vc == OVC_W'(v)) ? 1 : 0;
        dec = (sa_w >= 0 && m_ovc[sa_w] == v) ? 1 : 0;
        m_cnt[v] = m_cnt[v] + inc - dec;
        if (m_cnt[v] > CREDIT_MAX) begin
          m_cnt[v] = CREDIT_MAX;
          m_err    = 1;
        end
      end
      if (sa_w >= 0) begin
        m_sa_ptr = (sa_w + 1) % NUM_IN;
        if (req_tail[sa_w]) begin
          m_has[sa_w] = 0;
          m_busy[m_ovc[sa_w]] = 0;
        end
        src_pos[sa_w]++;
      end
      if (va_w >= 0 && free_v >= 0) begin
        m_has[va_w]  = 1;
        m_ovc[va_w]  = free_v;
        m_busy[free_v] = 1;
        m_va_ptr = (va_w + 1) % NUM_IN;
      end
    end
  end

  // Advance one cycle; inputs refreshed just after the edge, checks at edge+2.
  task automatic step();
    @(posedge clk);
    #1;
    credit_valid = 1'b0;
    drive_inputs();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("gnt_during_rst", gnt, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin src_len[i] = 0; src_pos[i] = 0; end
    drive_inputs();
    #1;
    chk("rst_ovc_busy", ovc_busy, 0);
    chk("rst_credit_cnt", credit_cnt, 12'h924);
    chk("rst_credit_err", credit_err, 0);
    chk("rst_gnt", gnt, 0);
  endtask

  initial begin
    int g;
    bit seen;
    logic [NUM_IN-1:0] e;

    for (int i = 0; i < NUM_IN; i++) begin src_len[i] = 0; src_pos[i] = 0; end
    credit_valid = 1'b0;
    credit_vc    = '0;
    drive_inputs();
    step();
    step();
    rst = 1'b0;
    #1;
    chk("init_ovc_busy", ovc_busy, 0);
    chk("init_credit_cnt", credit_cnt, 12'h924);
    chk("init_credit_err", credit_err, 0);

    // Single-flit packet on input 3.
    new_pkt(3, 1);
    drive_inputs();
    #1;
    chk("s1_no_gnt_before_va", gnt, 0);
    step();
    chk("s1_gnt", gnt, 20'h00008);
    chk("s1_gnt_ovc", gnt_ovc, 0);
    chk("s1_busy", ovc_busy, 4'h1);
    step();
    chk("s1_released", ovc_busy, 0);
    chk("s1_cnt0", credit_cnt[2:0], 3);

    // Five heads, four VCs: input 4 waits for the first release.
    do_reset();
    for (int i = 0; i < 4; i++) new_pkt(i, 3);
    new_pkt(4, 1);
    drive_inputs();
    for (int k = 0; k < 4; k++) begin
      step();
      e = '0;
      e[k] = 1'b1;
      chk("s2_first_grants", gnt, e);
      chk("s2_first_ovc", gnt_ovc, k);
    end
    chk("s2_all_busy", ovc_busy, 4'hF);
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      if (gnt[4]) seen = 1'b1;
      else step();
    end
    chk("s2_in4_granted", seen, 1);
    if (seen) chk("s2_in4_ovc", gnt_ovc, 0);

    // Six-flit packet with no returns: four grants then stall.
    do_reset();
    new_pkt(6, 6);
    drive_inputs();
    g = 0;
    repeat (5) begin step(); if (gnt[6]) g++; end
    chk("s3_grants_before_stall", g, 4);
    chk("s3_stalled_gnt", gnt, 0);
    chk("s3_cnt0_zero", credit_cnt[2:0], 0);
    chk("s3_vc_kept", ovc_busy, 4'h1);
    credit_valid = 1'b1;
    credit_vc    = 2'd0;
    g = 0;
    repeat (4) begin step(); if (gnt[6]) g++; end
    chk("s3_one_credit_one_grant", g, 1);
    chk("s3_vc_still_busy", ovc_busy, 4'h1);

    // Inputs 2 and 5 alternate once both own VCs.
    do_reset();
    new_pkt(2, 8);
    new_pkt(5, 8);
    drive_inputs();
    repeat (2) step();
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 0) ? 20'h00020 : 20'h00004;
      chk("s4_alternate", gnt, e);
      step();
    end

    // Grant and return on VC1 together, then an overflow return.
    do_reset();
    new_pkt(0, 8);
    new_pkt(1, 8);
    drive_inputs();
    repeat (2) step();
    chk("s5_gnt_in1", gnt, 20'h00002);
    chk("s5_gnt_ovc1", gnt_ovc, 1);
    credit_valid = 1'b1;
    credit_vc    = 2'd1;
    step();
    chk("s5_cnt1_unchanged", credit_cnt[5:3], 4);
    chk("s5_no_err", credit_err, 0);
    chk("s5_gnt_in0", gnt, 20'h00001);
    credit_valid = 1'b1;
    credit_vc    = 2'd1;
    step();
    chk("s5_cnt1_saturated", credit_cnt[5:3], 4);
    chk("s5_err_set", credit_err, 1);

    // Reset with packets in flight and the error flag set.
    do_reset();

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
